// File: rtl/mio_bus_arbiter_pkg.sv
// Shared types for the CPU_MIO bus arbiter: FSM state encoding, grant IDs and
// the IF/MEM arbitration rule.
package mio_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS_IF  = 2'd1,
        ST_BUS_MEM = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    // Single requester wins outright; a tie favours MEM unless MEM had the last grant.
    function automatic gnt_e arb_pick(input logic if_p, input logic mem_p, input gnt_e last);
        gnt_e pick;
        if (if_p && mem_p) begin
            if (last == GNT_MEM) pick = GNT_IF;
            else                 pick = GNT_MEM;
        end else if (mem_p) begin
            pick = GNT_MEM;
        end else begin
            pick = GNT_IF;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mio_bus_arbiter_timeout_ctr.sv
// Wait-state counter for the bus arbiter; exists only when MIO_TIMEOUT_EN is
// defined. expire flags the wait cycle that brings the count to LIMIT.
`ifdef MIO_TIMEOUT_EN
module mio_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (inc) cnt_d = cnt_q + W'(1);
    end

    assign expire = inc && (cnt_q == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule
`endif

// File: rtl/mio_bus_arbiter.sv
// Shares the CPU_MIO port between instruction fetch (IF) and data access (MEM).
// Define MIO_TIMEOUT_EN to abort stuck bus cycles and raise a sticky bus_err.
module mio_bus_arbiter
    import mio_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              bus_err
);

    state_e            state_q,     state_d;
    gnt_e              last_gnt_q,  last_gnt_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic              bus_we_q,    bus_we_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              mem_done_q,  mem_done_d;

    logic grant_fire;
    gnt_e gnt_sel;
    logic finish;
    logic expire;

`ifdef MIO_TIMEOUT_EN
    logic wait_cycle;
    logic bus_err_q;

    assign wait_cycle = (state_q != ST_IDLE) && !bus_ready;

    mio_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (grant_fire),
        .inc    (wait_cycle),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       bus_err_q <= 1'b0;
        else if (expire) bus_err_q <= 1'b1;
    end

    assign bus_err = bus_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign expire         = 1'b0;
    assign bus_err        = 1'b0;
`endif

    // An aborted (timed-out) cycle completes like a normal one but returns zero data.
    assign finish = (state_q != ST_IDLE) && (bus_ready || expire);

    // NOTE: every signal written below gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        grant_fire  = 1'b0;
        gnt_sel     = GNT_IF;

        case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    grant_fire = 1'b1;
                    gnt_sel    = arb_pick(if_req, mem_req, last_gnt_q);
                end
            end
            ST_BUS_IF: begin
                if (finish) begin
                    if_done_d  = 1'b1;
                    if_rdata_d = expire ? '0 : bus_rdata;
                    if (mem_req) begin
                        grant_fire = 1'b1;
                        gnt_sel    = GNT_MEM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BUS_MEM: begin
                if (finish) begin
                    mem_done_d  = 1'b1;
                    mem_rdata_d = expire ? '0 : bus_rdata;
                    if (if_req) begin
                        grant_fire = 1'b1;
                        gnt_sel    = GNT_IF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_fire) begin
            last_gnt_d = gnt_sel;
            if (gnt_sel == GNT_MEM) begin
                state_d     = ST_BUS_MEM;
                bus_addr_d  = mem_addr;
                bus_we_d    = mem_we;
                bus_wdata_d = mem_wdata;
            end else begin
                state_d     = ST_BUS_IF;
                bus_addr_d  = if_addr;
                bus_we_d    = 1'b0;
                bus_wdata_d = '0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= GNT_IF;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // bus_req follows the state flop, so an asynchronous reset drops it at once.
    assign bus_req   = (state_q != ST_IDLE);
    assign bus_we    = bus_we_q && (state_q == ST_BUS_MEM);
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign stall     = (if_req && !if_done_q) || (mem_req && !mem_done_q);

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
Shares the single CPU_MIO memory/IO port between the pipelined CPU's instruction-fetch requester (IF) and data-access requester (MEM).
- Sequences each bus transaction under the MIO_ready handshake.
- Returns read data to the granted requester.
- Drives pipeline stall while any request is outstanding.
- Sits between the CPU core and the memory/IO bus fabric.

Parameters:
ADDR_W, 32, address width of both requesters and the bus
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, wait-state limit before bus error (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, registered
if_done  out  1  one-cycle completion pulse for fetch
mem_req  in  1  data request; held until mem_done
mem_we  in  1  1 = write, 0 = read
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, registered
mem_done  out  1  one-cycle completion pulse for data
stall  out  1  pipeline freeze request
bus_req  out  1  bus cycle active (CPU_MIO)
bus_we  out  1  bus write strobe (mem_w)
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_rdata  in  DATA_W  bus read data
bus_ready  in  1  slave ready (MIO_ready)
bus_err  out  1  sticky timeout error (constant 0 without the optional feature)

Behaviour:
- Reset: state IDLE; all outputs are 0, including rdata registers, done pulses, bus_* and bus_err.
- FSM states: IDLE, BUS_IF, BUS_MEM.
- IDLE: on a clock edge with any request pending, register the grant and the bus_addr/bus_we/bus_wdata values, then enter BUS_x. bus_req is 1 in every BUS_x cycle.
- Arbitration:
  - Only one requester pending: grant it.
  - Both pending: grant MEM, unless the previous grant was MEM, in which case grant IF.
  - The last-grant flag resets to IF.
- BUS_x: bus outputs stay stable until bus_ready is sampled 1 at a clock edge. At that edge:
  - Latch bus_rdata into x_rdata. This happens for writes too; mem_rdata is then don't-care but deterministic.
  - Pulse x_done for the following cycle.
  - If the other requester is pending (its done not being issued this cycle), go directly to its BUS_ state. Otherwise go to IDLE.
- Latency:
  - Minimum is 2 cycles from req sampled to done asserted (1 grant cycle, 1 bus cycle with bus_ready=1).
  - Each bus_ready=0 cycle adds 1 cycle.
- bus_we is forced to 0 in BUS_IF.
- stall = (if_req & ~if_done) | (mem_req & ~mem_done), combinational.
- A requester must drop req in the cycle its done is high, or issue a new request. A req held high through done is treated as a new request.
- A req withdrawn mid-transaction: the bus cycle completes and done still pulses (protocol violation, no corruption).
- Reset mid-transaction: bus_req drops asynchronously and the in-flight transaction is discarded. No done pulse is issued.
- Addresses pass through unmodified; the block does no alignment checking.

Optional Feature:
MIO_TIMEOUT_EN
- With the macro defined, a wait counter clears on entry to each BUS_ state and increments on every bus_ready=0 cycle.
- When the counter reaches TIMEOUT_CYCLES:
  - The transaction is aborted.
  - x_done pulses with x_rdata = 0.
  - bus_err is set and remains set until reset.
  - The FSM proceeds as on normal completion.
- Without the macro, no counter is built, transactions wait indefinitely, and bus_err is tied to 0.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_BUS_IF=2'd1, ST_BUS_MEM=2'd2;
  - grant IDs GNT_IF=1'b0, GNT_MEM=1'b1.
- One natural sub-module, mio_timeout_ctr: loadable wait counter with terminal flag, instantiated only under MIO_TIMEOUT_EN.

Test Plan:
- Fetch only, if_addr=0x00000004, bus_ready held 1, bus_rdata=0x8C010000 -> bus_req high in cycle 1, if_done high in cycle 2, if_rdata=0x8C010000, stall high in cycles 0-1 only.
- Data write, mem_addr=0x00000010, mem_wdata=0xDEADBEEF, bus_ready=0 for 3 cycles -> bus_we=1 and bus_addr/bus_wdata stable for 4 bus cycles, mem_done at cycle 5, no bus activity after.
- if_req and mem_req raised together, both held, bus_ready=1 -> grant order MEM, IF, MEM, IF; back-to-back BUS_ states with no IDLE gap; bus_we=0 in every IF cycle.
- Reset asserted in the 2nd wait cycle of a MEM read -> bus_req=0 immediately, no mem_done, mem_rdata=0, FSM IDLE; after release a pending if_req is served normally.
- With MIO_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus_ready stuck 0 -> if_done after 4 wait cycles, if_rdata=0, bus_err=1 and remains 1 during subsequent normal transactions.
